// File: rtl/seg_disp_pkg.sv
// Shared constants and types for the multiplexed six-digit seven-segment display.
package seg_disp_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int CODE_W     = 4;

    localparam logic [6:0]            SEG_OFF = 7'h00;
    localparam logic [NUM_DIGITS-1:0] ENB_OFF = 6'h3F;

    // Segment order is {g,f,e,d,c,b,a}, active high.
    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    typedef enum logic {
        PH_BLANK,
        PH_SHOW
    } phase_t;

    typedef struct packed {
        logic                         lzb;
        logic [NUM_DIGITS-1:0]        dp;
        logic [NUM_DIGITS*CODE_W-1:0] digits;
    } frame_t;

endpackage

// File: rtl/seg_hex_dec.sv
// Combinational 4-bit code to seven-segment glyph decoder (0-9, A b C d E F).
module seg_hex_dec
    import seg_disp_pkg::*;
(
    input  logic [CODE_W-1:0] code_i,
    output logic [6:0]        seg_o
);

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        seg_o = SEG_OFF;
        case (code_i)
            4'h0: seg_o = GLYPH_0;
            4'h1: seg_o = GLYPH_1;
            4'h2: seg_o = GLYPH_2;
            4'h3: seg_o = GLYPH_3;
            4'h4: seg_o = GLYPH_4;
            4'h5: seg_o = GLYPH_5;
            4'h6: seg_o = GLYPH_6;
            4'h7: seg_o = GLYPH_7;
            4'h8: seg_o = GLYPH_8;
            4'h9: seg_o = GLYPH_9;
            4'hA: seg_o = GLYPH_A;
            4'hB: seg_o = GLYPH_B;
            4'hC: seg_o = GLYPH_C;
            4'hD: seg_o = GLYPH_D;
            4'hE: seg_o = GLYPH_E;
            4'hF: seg_o = GLYPH_F;
            default: seg_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seg_scan_disp.sv
// Six-digit multiplexed seven-segment scanner with per-slot blanking, frame-aligned
// double-buffered updates and leading-zero suppression. All outputs come from flops.
module seg_scan_disp
    import seg_disp_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_DIGITS*CODE_W-1:0] i_digits,
    input  logic [NUM_DIGITS-1:0]        i_dp,
    input  logic                         i_lzb,
    input  logic                         i_load,
    output logic                         o_ack,
    output logic                         o_frame,
    output logic [6:0]                   o_seg,
    output logic                         o_seg_dp,
    output logic [NUM_DIGITS-1:0]        o_seg_enb
);

    localparam int               CNT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);
    localparam logic [2:0]       IDX_LAST  = 3'(NUM_DIGITS - 1);

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [2:0]            idx_q, idx_d;
    frame_t                stage_q, stage_d;
    frame_t                disp_q, disp_d;
    logic                  pending_q, pending_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [NUM_DIGITS-1:0] enb_q, enb_d;
    logic                  ack_q, ack_d;
    logic                  frame_q, frame_d;

    phase_t                phase_d;
    logic                  slot_end;
    logic                  boundary;
    frame_t                load_data;
    logic [CODE_W-1:0]     code;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] blank_mask;
    logic                  zero_run;

    assign load_data = {i_lzb, i_dp, i_digits};

    always_comb begin
        slot_end = (cnt_q == CNT_LAST);
        boundary = slot_end && (idx_q == IDX_LAST);
        cnt_d    = slot_end ? '0 : cnt_q + CNT_W'(1);
        idx_d    = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 3'd1;
        end
        phase_d = (cnt_d < BLANK_END) ? PH_BLANK : PH_SHOW;
    end

    // A load on the boundary cycle itself wins over older staged data.
    always_comb begin
        stage_d   = stage_q;
        pending_d = pending_q;
        disp_d    = disp_q;
        ack_d     = 1'b0;
        frame_d   = boundary;
        if (i_load) begin
            stage_d   = load_data;
            pending_d = 1'b1;
        end
        if (boundary && (pending_q || i_load)) begin
            disp_d    = i_load ? load_data : stage_q;
            pending_d = 1'b0;
            ack_d     = 1'b1;
        end
    end

    // Blank digits 5..1 while everything from the top down to them is zero.
    always_comb begin
        blank_mask = '0;
        zero_run   = 1'b1;
        for (int k = NUM_DIGITS - 1; k > 0; k--) begin
            zero_run      = zero_run && (disp_d.digits[k*CODE_W +: CODE_W] == '0);
            blank_mask[k] = zero_run && disp_d.lzb;
        end
    end

    assign code = disp_d.digits[int'(idx_d)*CODE_W +: CODE_W];

    seg_hex_dec u_dec (
        .code_i (code),
        .seg_o  (glyph)
    );

    // Outputs are computed from next-state so the flopped values line up with cnt_q/idx_q.
    always_comb begin
        seg_d = SEG_OFF;
        dp_d  = 1'b0;
        enb_d = ENB_OFF;
        if (phase_d == PH_SHOW) begin
            enb_d[idx_d] = 1'b0;
            seg_d        = blank_mask[idx_d] ? SEG_OFF : glyph;
            dp_d         = disp_d.dp[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            stage_q   <= '0;
            disp_q    <= '0;
            pending_q <= 1'b0;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b0;
            enb_q     <= ENB_OFF;
            ack_q     <= 1'b0;
            frame_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            stage_q   <= stage_d;
            disp_q    <= disp_d;
            pending_q <= pending_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            enb_q     <= enb_d;
            ack_q     <= ack_d;
            frame_q   <= frame_d;
        end
    end

    assign o_seg     = seg_q;
    assign o_seg_dp  = dp_q;
    assign o_seg_enb = enb_q;
    assign o_ack     = ack_q;
    assign o_frame   = frame_q;

endmodule

// File: tb/tb_seg_scan_disp.sv
// Self-checking bench for seg_scan_disp: directed scenarios plus random loads,
// compared cycle by cycle against a time-indexed behavioural model.
module tb_seg_scan_disp;

    localparam int SD    = 8;
    localparam int BC    = 2;
    localparam int ND    = 6;
    localparam int FRAME = SD * ND;

    logic        clk    = 1'b0;
    logic        clk_en = 1'b1;
    logic        rst_n  = 1'b0;
    logic [23:0] i_digits = '0;
    logic [5:0]  i_dp     = '0;
    logic        i_lzb    = 1'b0;
    logic        i_load   = 1'b0;
    logic        o_ack, o_frame, o_seg_dp;
    logic [6:0]  o_seg;
    logic [5:0]  o_seg_enb;

    int checks = 0;
    int errors = 0;

    // Model: t = clock edges since reset release; data words are {lzb, dp[5:0], digits[23:0]}.
    int          t       = 0;
    logic [30:0] stg     = '0;
    logic [30:0] disp    = '0;
    logic        pend    = 1'b0;
    logic        exp_ack = 1'b0;

    logic [6:0] glyph_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    seg_scan_disp #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_digits  (i_digits),
        .i_dp      (i_dp),
        .i_lzb     (i_lzb),
        .i_load    (i_load),
        .o_ack     (o_ack),
        .o_frame   (o_frame),
        .o_seg     (o_seg),
        .o_seg_dp  (o_seg_dp),
        .o_seg_enb (o_seg_enb)
    );

    initial forever begin
        #5;
        if (clk_en) clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp_v);
        end
    endtask

    task automatic check_outputs();
        int          cnt, idx;
        logic [23:0] upper;
        logic [6:0]  e_seg;
        logic [5:0]  e_enb;
        logic        e_dp;
        cnt   = t % SD;
        idx   = (t / SD) % ND;
        e_seg = 7'h00;
        e_enb = 6'h3F;
        e_dp  = 1'b0;
        if (cnt >= BC) begin
            e_enb = 6'h3F ^ (6'd1 << idx);
            upper = disp[23:0] >> (4 * idx);
            e_seg = (disp[30] && idx != 0 && upper == 24'd0) ? 7'h00 : glyph_tbl[upper[3:0]];
            e_dp  = disp[24 + idx];
        end
        check("seg_enb", {2'b0, o_seg_enb}, {2'b0, e_enb});
        check("seg",     {1'b0, o_seg},     {1'b0, e_seg});
        check("seg_dp",  {7'b0, o_seg_dp},  {7'b0, e_dp});
        check("ack",     {7'b0, o_ack},     {7'b0, exp_ack});
        check("frame",   {7'b0, o_frame},   {7'b0, (t % FRAME == 0) && (t != 0)});
    endtask

    // Advance one clock; the model absorbs exactly what the DUT samples on that edge.
    task automatic tick();
        if (i_load) begin
            stg  = {i_lzb, i_dp, i_digits};
            pend = 1'b1;
        end
        exp_ack = 1'b0;
        if (t % FRAME == FRAME - 1 && pend) begin
            disp    = stg;
            pend    = 1'b0;
            exp_ack = 1'b1;
        end
        @(posedge clk);
        #1;
        t++;
        i_load   = 1'b0;
        i_digits = 24'($urandom);
        i_dp     = 6'($urandom);
        i_lzb    = 1'($urandom);
    endtask

    task automatic cycle();
        tick();
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic run_to(input int pos);
        int guard = 0;
        while (t % FRAME != pos && guard < 2 * FRAME) begin
            cycle();
            guard++;
        end
    endtask

    task automatic load(input logic [23:0] d, input logic [5:0] p, input logic z);
        i_digits = d;
        i_dp     = p;
        i_lzb    = z;
        i_load   = 1'b1;
        cycle();
    endtask

    task automatic model_reset();
        t       = 0;
        stg     = '0;
        disp    = '0;
        pend    = 1'b0;
        exp_ack = 1'b0;
    endtask

    function automatic logic [23:0] rnd_digits();
        return 24'($urandom) >> (4 * $urandom_range(0, 6));
    endfunction

    initial begin
        int en0;
        int acks;

        // Reset held with activity on the inputs.
        rst_n    = 1'b0;
        i_load   = 1'b1;
        i_digits = 24'hABCDEF;
        i_dp     = 6'h3F;
        repeat (3) @(posedge clk);
        #1;
        check("rst_enb",   {2'b0, o_seg_enb}, 8'h3F);
        check("rst_seg",   {1'b0, o_seg},     8'h00);
        check("rst_dp",    {7'b0, o_seg_dp},  8'h00);
        check("rst_ack",   {7'b0, o_ack},     8'h00);
        check("rst_frame", {7'b0, o_frame},   8'h00);

        // Release and watch slot 0 of the first frame.
        i_load = 1'b0;
        rst_n  = 1'b1;
        model_reset();
        check_outputs();
        en0 = (o_seg_enb == 6'b111110) ? 1 : 0;
        repeat (SD - 1) begin
            cycle();
            if (o_seg_enb == 6'b111110) en0++;
        end
        check("slot0_en_count", 8'(en0), 8'd6);
        run_to(0);

        // Plain load, no blanking.
        run_to(10);
        load(24'h123456, 6'b000100, 1'b0);
        run_to(0);
        check("load_ack",   {7'b0, o_ack},   8'h01);
        check("load_frame", {7'b0, o_frame}, 8'h01);
        run_to(2);
        check("load_d0", {1'b0, o_seg}, 8'h7D);
        run_to(2 * SD + 2);
        check("load_d2",    {1'b0, o_seg},    8'h66);
        check("load_d2_dp", {7'b0, o_seg_dp}, 8'h01);
        run_to(0);

        // Leading-zero blanking.
        run_to(20);
        load(24'h000507, 6'b000000, 1'b1);
        run_to(0);
        run_to(SD + 2);
        check("lzb_d1", {1'b0, o_seg}, 8'h3F);
        run_to(2 * SD + 2);
        check("lzb_d2", {1'b0, o_seg}, 8'h6D);
        run_to(4 * SD + 3);
        check("lzb_d4_enb", {2'b0, o_seg_enb}, 8'h2F);
        check("lzb_d4_seg", {1'b0, o_seg},     8'h00);
        run_to(0);

        // All zeros with blanking: only digit 0 lit.
        load(24'h000000, 6'b100000, 1'b1);
        run_to(0);
        run_to(2);
        check("zero_d0", {1'b0, o_seg}, 8'h3F);
        run_to(5 * SD + 4);
        check("zero_d5_seg", {1'b0, o_seg},    8'h00);
        check("zero_d5_dp",  {7'b0, o_seg_dp}, 8'h01);
        run_to(0);

        // Two loads in one frame: one ack, only the later data shown.
        run_to(2 * SD + 3);
        load(24'hABCDEF, 6'h3F, 1'b0);
        run_to(4 * SD + 3);
        load(24'h987654, 6'h00, 1'b1);
        acks = 0;
        while (t % FRAME != 0) begin
            cycle();
            if (o_ack) acks++;
        end
        repeat (FRAME - 1) begin
            cycle();
            if (o_ack) acks++;
        end
        check("dbl_ack_count", 8'(acks), 8'd1);
        run_to(0);
        run_to(5 * SD + 2);
        check("dbl_d5", {1'b0, o_seg}, 8'h6F);
        run_to(0);

        // Load presented on the boundary cycle itself.
        run_to(FRAME - 1);
        load(24'hFEDCBA, 6'b000001, 1'b0);
        check("bnd_ack", {7'b0, o_ack}, 8'h01);
        run_to(2);
        check("bnd_d0",    {1'b0, o_seg},    8'h77);
        check("bnd_d0_dp", {7'b0, o_seg_dp}, 8'h01);
        run_to(0);

        // Random loads at random points.
        repeat (4 * FRAME) begin
            if ($urandom_range(0, 15) == 0) load(rnd_digits(), 6'($urandom), 1'($urandom));
            else cycle();
        end

        // Asynchronous reset in the middle of digit 3, clock stopped.
        run_to(0);
        load(24'h4321AB, 6'h2A, 1'b0);
        run_to(0);
        run_to(10);
        load(24'h555555, 6'h00, 1'b0);
        run_to(3 * SD + 4);
        check("pre_rst_enb", {2'b0, o_seg_enb}, 8'h37);
        clk_en = 1'b0;
        #20;
        rst_n = 1'b0;
        #1;
        check("mid_rst_enb",   {2'b0, o_seg_enb}, 8'h3F);
        check("mid_rst_seg",   {1'b0, o_seg},     8'h00);
        check("mid_rst_dp",    {7'b0, o_seg_dp},  8'h00);
        check("mid_rst_ack",   {7'b0, o_ack},     8'h00);
        check("mid_rst_frame", {7'b0, o_frame},   8'h00);
        #10;
        rst_n = 1'b1;
        model_reset();
        check_outputs();
        clk_en = 1'b1;
        run(FRAME + 2 * SD);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
